servant_timer: RTL and testbench
================================

SERVANT_TIMER -- requirements
Module: servant_timer

Interface
REQ-001 Parameter WIDTH, default 32, sets the width of the counter, the compare register and the data bus.
REQ-002 Parameter DIV, default 1, sets the prescaler divide ratio; range 1..65536.
REQ-003 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 i_rst  in  1  reset; asynchronous and active-high.
REQ-005 i_wb_adr  in  2  word select: 0 MTIME, 1 MTIMECMP, 2 CTRL, 3 STATUS; driven from cpu_adr[3:2] by the bus mux.
REQ-006 i_wb_dat  in  WIDTH  write data.
REQ-007 i_wb_we  in  1  write enable, qualified by i_wb_cyc.
REQ-008 i_wb_cyc  in  1  cycle request, already address-decoded by the mux.
REQ-009 o_wb_rdt  out  WIDTH  read data; the mux generates ack.
REQ-010 o_irq  out  1  timer interrupt to the CPU, level, registered.

Function
REQ-011 Registers:
- MTIME (rw): counter.
- MTIMECMP (rw): compare value.
- CTRL (rw): bit0 EN, bit1 IRQ_EN, bit2 PERIODIC; other bits read 0.
- STATUS: bit0 PENDING; write-1-to-clear; other bits read 0.
REQ-012 o_wb_rdt is combinational from i_wb_adr, valid in every cycle i_wb_cyc is high.
REQ-013 A Wishbone cycle lasts 2 clocks (request, ack). A write takes effect exactly once, on the first clock of i_wb_cyc & i_wb_we. Internal flag wr_done is set on that clock and cleared when i_wb_cyc is low.
REQ-014 Prescaler: counter 0..DIV-1 runs only while EN=1.
- tick=1 when the counter equals DIV-1; the counter then wraps to 0.
- DIV=1 gives a tick every enabled clock.
REQ-015 On tick:
- If PERIODIC=1 and MTIME==MTIMECMP: MTIME <= 0.
- Otherwise: MTIME <= MTIME+1, wrapping from 2^WIDTH-1 to 0.
REQ-016 PENDING <= 1 on any tick with MTIME==MTIMECMP, in both modes, so the period is MTIMECMP+1 ticks.
REQ-017 o_irq <= PENDING & IRQ_EN, registered; it rises 2 clocks after the matching tick.
REQ-018 A write to MTIME on the same clock as a tick: the write wins and the prescaler is reset to 0.
REQ-019 A write of EN=0 freezes MTIME and resets the prescaler to 0.
REQ-020 A PENDING W1C on the same clock as a set event: the set wins.
REQ-021 Writing MTIMECMP does not alter PENDING; only a subsequent tick match sets it.
REQ-022 i_wb_cyc low: no register changes except counter/prescaler/PENDING/o_irq behaviour per REQ-014..REQ-017.

Reset
REQ-023 Under i_rst: MTIME=0, MTIMECMP=all-ones, CTRL=0, PENDING=0, prescaler=0, wr_done=0, o_irq=0.
REQ-024 Reset asserted mid-cycle aborts any write in progress; no partial register update is permitted.

Structure
REQ-025 Register offsets (MTIME, MTIMECMP, CTRL, STATUS) and CTRL/STATUS bit positions are constants in the shared servant package; the bus mux decode uses the same package.
REQ-026 The prescaler is a separate sub-module, servant_prescaler, with ports i_clk, i_rst, i_en, i_clr and o_tick, parameter DIV.
REQ-027 No other sub-modules.

Verification
REQ-028 DIV=1: write MTIMECMP=5, then CTRL=0b011 -> PENDING set after the tick with MTIME==5; o_irq high one clock later; MTIME continues to 6, 7...
REQ-029 DIV=4, PERIODIC: CTRL=0b111, MTIMECMP=2 -> MTIME sequence 0,1,2,0,... with each value held 4 clocks; o_irq re-asserts every 12 clocks after W1C.
REQ-030 Write STATUS=1 in the same clock as a match tick -> PENDING stays 1 and o_irq stays high.
REQ-031 Write MTIME=0xFFFFFFFE, EN=1, DIV=1 -> reads 0xFFFFFFFF then 0x00000000; no PENDING with MTIMECMP=0x10.
REQ-032 Two-clock write cycle of MTIME=0x100 while enabled -> MTIME=0x100 on the first clock, 0x101 on the next tick; no double load.
REQ-033 Assert i_rst during a write cycle -> all registers at reset values, o_irq=0, and the register targeted by the aborted write is unchanged after reset release.

Source files
------------

// File: rtl/servant_timer_pkg.sv
// Shared constants for the servant timer: register word offsets, CTRL/STATUS
// bit positions, and a sizing helper for the prescaler counter.
package servant_timer_pkg;

  localparam logic [1:0] ADR_MTIME    = 2'd0;
  localparam logic [1:0] ADR_MTIMECMP = 2'd1;
  localparam logic [1:0] ADR_CTRL     = 2'd2;
  localparam logic [1:0] ADR_STATUS   = 2'd3;

  localparam int CTRL_EN_BIT        = 0;
  localparam int CTRL_IRQ_EN_BIT    = 1;
  localparam int CTRL_PERIODIC_BIT  = 2;
  localparam int STATUS_PENDING_BIT = 0;

  typedef struct packed {
    logic periodic;
    logic irq_en;
    logic en;
  } ctrl_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/servant_prescaler.sv
// Divide-by-DIV enable generator: counts 0..DIV-1 while enabled and pulses
// o_tick on the last count. i_clr forces the count back to 0.
module servant_prescaler
  import servant_timer_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en & (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/servant_timer.sv
// Memory-mapped machine timer: MTIME counter advanced by a prescaler tick,
// MTIMECMP match sets a sticky PENDING flag that drives a registered IRQ.
module servant_timer
  import servant_timer_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter int unsigned DIV   = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_wb_adr,
  input  logic [WIDTH-1:0] i_wb_dat,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  output logic [WIDTH-1:0] o_wb_rdt,
  output logic             o_irq
);

  logic [WIDTH-1:0] r_mtime;
  logic [WIDTH-1:0] r_mtimecmp;
  ctrl_t            r_ctrl;
  logic             r_pending;
  logic             r_wr_done;
  logic             r_irq;

  logic             w_wr;
  logic             w_wr_mtime;
  logic             w_wr_cmp;
  logic             w_wr_ctrl;
  logic             w_wr_status;
  logic             w_tick;
  logic             w_hit;
  logic             w_pre_clr;
  logic [WIDTH-1:0] w_rdt;

  // The bus holds cyc for two clocks; only the first one may write.
  assign w_wr        = i_wb_cyc & i_wb_we & ~r_wr_done;
  assign w_wr_mtime  = w_wr & (i_wb_adr == ADR_MTIME);
  assign w_wr_cmp    = w_wr & (i_wb_adr == ADR_MTIMECMP);
  assign w_wr_ctrl   = w_wr & (i_wb_adr == ADR_CTRL);
  assign w_wr_status = w_wr & (i_wb_adr == ADR_STATUS);

  assign w_hit     = w_tick & (r_mtime == r_mtimecmp);
  assign w_pre_clr = w_wr_mtime | (w_wr_ctrl & ~i_wb_dat[CTRL_EN_BIT]);

  servant_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (r_ctrl.en),
    .i_clr  (w_pre_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_done <= 1'b0;
    end else if (!i_wb_cyc) begin
      r_wr_done <= 1'b0;
    end else if (w_wr) begin
      r_wr_done <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_ctrl     <= '0;
      r_pending  <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      // A bus write to MTIME overrides whatever the tick would have done.
      if (w_wr_mtime) begin
        r_mtime <= i_wb_dat;
      end else if (w_tick) begin
        r_mtime <= (r_ctrl.periodic && (r_mtime == r_mtimecmp)) ? '0 : r_mtime + 1'b1;
      end

      if (w_wr_cmp) begin
        r_mtimecmp <= i_wb_dat;
      end

      if (w_wr_ctrl) begin
        r_ctrl.en       <= i_wb_dat[CTRL_EN_BIT];
        r_ctrl.irq_en   <= i_wb_dat[CTRL_IRQ_EN_BIT];
        r_ctrl.periodic <= i_wb_dat[CTRL_PERIODIC_BIT];
      end

      // Set beats a simultaneous write-1-to-clear so no match is lost.
      if (w_hit) begin
        r_pending <= 1'b1;
      end else if (w_wr_status && i_wb_dat[STATUS_PENDING_BIT]) begin
        r_pending <= 1'b0;
      end

      r_irq <= r_pending & r_ctrl.irq_en;
    end
  end

  always_comb begin
    w_rdt = '0;
    case (i_wb_adr)
      ADR_MTIME:    w_rdt = r_mtime;
      ADR_MTIMECMP: w_rdt = r_mtimecmp;
      ADR_CTRL: begin
        w_rdt[CTRL_EN_BIT]       = r_ctrl.en;
        w_rdt[CTRL_IRQ_EN_BIT]   = r_ctrl.irq_en;
        w_rdt[CTRL_PERIODIC_BIT] = r_ctrl.periodic;
      end
      default:      w_rdt[STATUS_PENDING_BIT] = r_pending;
    endcase
  end

  assign o_wb_rdt = w_rdt;
  assign o_irq    = r_irq;

endmodule

// File: tb/tb_servant_timer.sv
// Directed bench for servant_timer: a register-access vector table on a DIV=1
// instance, then hand sequences for matching, W1C races, wrap, DIV=4 periodic
// mode and reset during a write.
module tb_servant_timer;

  localparam logic [1:0] A_MTIME  = 2'd0;
  localparam logic [1:0] A_CMP    = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic        wb_we  = 1'b0;
  logic        wb_cyc = 1'b0;
  logic [31:0] rdt1, rdt4;
  logic        irq1, irq4;

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  servant_timer #(.WIDTH(32), .DIV(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(wb_adr), .i_wb_dat(wb_dat),
    .i_wb_we(wb_we), .i_wb_cyc(wb_cyc), .o_wb_rdt(rdt1), .o_irq(irq1)
  );

  servant_timer #(.WIDTH(32), .DIV(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(wb_adr), .i_wb_dat(wb_dat),
    .i_wb_we(wb_we), .i_wb_cyc(wb_cyc), .o_wb_rdt(rdt4), .o_irq(irq4)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic do_reset();
    rst = 1'b1; wb_cyc = 1'b0; wb_we = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Two-clock write (request, ack) followed by one idle clock with cyc low.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = a; wb_dat = d;
    @(negedge clk); @(negedge clk);
    wb_cyc = 1'b0; wb_we = 1'b0;
    @(negedge clk);
  endtask

  // Combinational read: no clock edge is consumed.
  task automatic set_rd(input logic [1:0] a);
    wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = a;
    #1;
    wb_cyc = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sel_val(input int s);
    case (s)
      0:       return rdt1;
      1:       return rdt4;
      2:       return {31'b0, irq1};
      default: return {31'b0, irq4};
    endcase
  endfunction

  // Bounded poll: sel 0/1 read rdt of dut1/dut4 at address a, 2/3 irq1/irq4.
  task automatic wait_val(input logic [1:0] a, input int s, input logic [31:0] v, input string nm);
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      set_rd(a);
      if (sel_val(s) === v) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(nm, {31'b0, found}, 32'd1);
  endtask

  typedef struct {
    logic        rd;
    logic [1:0]  adr;
    logic [31:0] dat;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int c0;
    int c1;
    logic [31:0] e;

    vecs[0]  = '{1'b1, A_MTIME,  32'h0,        32'h0,        "rst_mtime"};
    vecs[1]  = '{1'b1, A_CMP,    32'h0,        32'hFFFFFFFF, "rst_cmp"};
    vecs[2]  = '{1'b1, A_CTRL,   32'h0,        32'h0,        "rst_ctrl"};
    vecs[3]  = '{1'b1, A_STATUS, 32'h0,        32'h0,        "rst_status"};
    vecs[4]  = '{1'b0, A_CMP,    32'h12345678, 32'h0,        ""};
    vecs[5]  = '{1'b1, A_CMP,    32'h0,        32'h12345678, "cmp_rb"};
    vecs[6]  = '{1'b0, A_CTRL,   32'hFFFFFFF4, 32'h0,        ""};
    vecs[7]  = '{1'b1, A_CTRL,   32'h0,        32'h00000004, "ctrl_mask"};
    vecs[8]  = '{1'b0, A_MTIME,  32'h0000A5A5, 32'h0,        ""};
    vecs[9]  = '{1'b1, A_MTIME,  32'h0,        32'h0000A5A5, "mtime_rb"};
    vecs[10] = '{1'b0, A_STATUS, 32'hFFFFFFFF, 32'h0,        ""};
    vecs[11] = '{1'b1, A_STATUS, 32'h0,        32'h0,        "status_idle"};
    vecs[12] = '{1'b0, A_CTRL,   32'h0,        32'h0,        ""};
    vecs[13] = '{1'b1, A_CTRL,   32'h0,        32'h0,        "ctrl_clr"};

    do_reset();
    check("rst_irq", {31'b0, irq1}, 32'd0);
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rd) begin
        set_rd(vecs[i].adr);
        check(vecs[i].nm, rdt1, vecs[i].exp);
      end else begin
        wr(vecs[i].adr, vecs[i].dat);
      end
    end

    // Compare match at MTIMECMP=5, one-shot mode.
    do_reset();
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'h3);
    wait_val(A_MTIME, 0, 32'd5, "a_reach5");
    set_rd(A_STATUS); check("a_pend_pre", rdt1, 32'd0);
    check("a_irq_pre", {31'b0, irq1}, 32'd0);
    step();
    set_rd(A_MTIME);  check("a_mtime6", rdt1, 32'd6);
    set_rd(A_STATUS); check("a_pend_set", rdt1, 32'd1);
    check("a_irq_lag", {31'b0, irq1}, 32'd0);
    step();
    set_rd(A_MTIME);  check("a_mtime7", rdt1, 32'd7);
    check("a_irq_high", {31'b0, irq1}, 32'd1);

    // W1C landing on the same clock as a match: set wins.
    wr(A_MTIME, 32'd2);
    wait_val(A_MTIME, 0, 32'd5, "b_reach5");
    wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = A_STATUS; wb_dat = 32'd1;
    @(negedge clk);
    check("b_pend_race", rdt1, 32'd1);
    check("b_irq_race", {31'b0, irq1}, 32'd1);
    @(negedge clk);
    wb_cyc = 1'b0; wb_we = 1'b0;
    check("b_irq_ack", {31'b0, irq1}, 32'd1);
    step();
    wr(A_STATUS, 32'd1);
    set_rd(A_STATUS); check("b_w1c", rdt1, 32'd0);
    check("b_irq_off", {31'b0, irq1}, 32'd0);

    // Wrap through 2^32 and a two-clock MTIME write while counting.
    do_reset();
    wr(A_CTRL, 32'h1);
    wr(A_CMP, 32'h10);
    wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = A_MTIME; wb_dat = 32'hFFFFFFFE;
    @(negedge clk); check("c_load", rdt1, 32'hFFFFFFFE);
    @(negedge clk); check("c_max", rdt1, 32'hFFFFFFFF);
    wb_cyc = 1'b0; wb_we = 1'b0;
    step();
    set_rd(A_MTIME);  check("c_wrap", rdt1, 32'h0);
    set_rd(A_STATUS); check("c_nopend", rdt1, 32'h0);
    wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = A_MTIME; wb_dat = 32'h100;
    @(negedge clk); check("d_load", rdt1, 32'h100);
    @(negedge clk); check("d_once", rdt1, 32'h101);
    wb_cyc = 1'b0; wb_we = 1'b0;
    step();
    set_rd(A_MTIME); check("d_next", rdt1, 32'h102);

    // DIV=4 periodic: 0,1,2,0 each held four clocks, IRQ every 12 clocks.
    do_reset();
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h7);
    wait_val(A_MTIME, 1, 32'd1, "e_reach1");
    for (int i = 0; i < 12; i++) begin
      e = (i < 4) ? 32'd1 : (i < 8) ? 32'd2 : 32'd0;
      set_rd(A_MTIME); check($sformatf("e_seq%0d", i), rdt4, e);
      if (i == 8) begin
        set_rd(A_STATUS); check("e_pend", rdt4, 32'd1);
        check("e_irq_lag", {31'b0, irq4}, 32'd0);
      end
      if (i == 9) check("e_irq_on", {31'b0, irq4}, 32'd1);
      step();
    end
    wr(A_STATUS, 32'd1);
    check("e_irq_clr", {31'b0, irq4}, 32'd0);
    wait_val(A_STATUS, 3, 32'd1, "e_rise0");
    c0 = cyc_cnt;
    wr(A_STATUS, 32'd1);
    check("e_irq_clr2", {31'b0, irq4}, 32'd0);
    wait_val(A_STATUS, 3, 32'd1, "e_rise1");
    c1 = cyc_cnt;
    check("e_period", 32'(c1 - c0), 32'd12);

    // Reset asserted during a write cycle aborts it.
    do_reset();
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h3);
    wait_val(A_STATUS, 2, 32'd1, "f_irq_up");
    wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = A_CMP; wb_dat = 32'h0000DEAD;
    #1 rst = 1'b1;
    #1 check("f_irq_async", {31'b0, irq1}, 32'd0);
    @(negedge clk);
    wb_cyc = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    set_rd(A_CMP);    check("f_cmp", rdt1, 32'hFFFFFFFF);
    set_rd(A_MTIME);  check("f_mtime", rdt1, 32'h0);
    set_rd(A_CTRL);   check("f_ctrl", rdt1, 32'h0);
    set_rd(A_STATUS); check("f_status", rdt1, 32'h0);
    check("f_irq", {31'b0, irq1}, 32'd0);
    step(); step();
    set_rd(A_CMP);    check("f_cmp_hold", rdt1, 32'hFFFFFFFF);
    set_rd(A_MTIME);  check("f_mtime_hold", rdt1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
